// File: rtl/link_config_loader_pkg.sv
// Shared types and constants for the link configuration loader.
// The stage codes mirror the global stage encoding used by the stage controller.
package link_config_loader_pkg;

    localparam int NUM_LINKS      = 4;
    localparam int MAX_WEIGHT     = 2;
    localparam int LINK_BIT_WIDTH = $clog2(MAX_WEIGHT + 1);
    localparam int CNT_WIDTH      = $clog2(NUM_LINKS + 1);

    localparam int STAGE_WIDTH = 3;
    localparam logic [STAGE_WIDTH-1:0] STAGE_IDLE               = 3'd0;
    localparam logic [STAGE_WIDTH-1:0] STAGE_PARAMETERS_LOADING = 3'd1;
    localparam logic [STAGE_WIDTH-1:0] STAGE_RUN                = 3'd2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_COMMIT,
        ST_DONE
    } loader_state_e;

    typedef struct packed {
        logic [LINK_BIT_WIDTH-1:0] weight;
        logic [1:0]                boundary;
    } link_cfg_t;

    function automatic logic weight_over(input logic [LINK_BIT_WIDTH-1:0] w);
        return w > LINK_BIT_WIDTH'(MAX_WEIGHT);
    endfunction

    function automatic logic [LINK_BIT_WIDTH-1:0] clamp_weight(input logic [LINK_BIT_WIDTH-1:0] w);
        return weight_over(w) ? LINK_BIT_WIDTH'(MAX_WEIGHT) : w;
    endfunction

endpackage

// File: rtl/link_config_loader_if.sv
// Host configuration stream: one (weight, boundary) word per valid/ready handshake.
interface link_config_loader_if;
    import link_config_loader_pkg::*;

    logic                      cfg_valid;
    logic                      cfg_ready;
    logic [LINK_BIT_WIDTH-1:0] cfg_weight;
    logic [1:0]                cfg_boundary;

    modport master (output cfg_valid, output cfg_weight, output cfg_boundary, input cfg_ready);
    modport slave  (input cfg_valid, input cfg_weight, input cfg_boundary, output cfg_ready);

endinterface

// File: rtl/link_config_loader_shift_chain.sv
// NUM_LINKS-deep shift register of link configs; clamps incoming weights and
// keeps a sticky flag whenever a clamp happened.
module link_cfg_shift_chain
    import link_config_loader_pkg::*;
(
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                shift_en,
    input  logic                                err_clr,
    input  link_cfg_t                           word_in,
    output logic [NUM_LINKS*LINK_BIT_WIDTH-1:0] weight_bus,
    output logic [NUM_LINKS*2-1:0]              boundary_bus,
    output logic                                cfg_error
);

    link_cfg_t entry_q [NUM_LINKS];
    link_cfg_t entry_d [NUM_LINKS];
    logic      cfg_error_q;
    logic      cfg_error_d;

    always_comb begin
        entry_d     = entry_q;
        cfg_error_d = cfg_error_q;
        if (err_clr) begin
            cfg_error_d = 1'b0;
        end
        if (shift_en) begin
            for (int i = 0; i < NUM_LINKS - 1; i++) begin
                entry_d[i] = entry_q[i+1];
            end
            entry_d[NUM_LINKS-1].weight   = clamp_weight(word_in.weight);
            entry_d[NUM_LINKS-1].boundary = word_in.boundary;
            if (weight_over(word_in.weight)) begin
                cfg_error_d = 1'b1;
            end
        end
    end

    // NOTE: this is a small register array, not a RAM, so every entry is reset
    // to give the links all-zero buses straight out of reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_LINKS; i++) begin
                entry_q[i] <= '0;
            end
            cfg_error_q <= 1'b0;
        end else begin
            entry_q     <= entry_d;
            cfg_error_q <= cfg_error_d;
        end
    end

    for (genvar g = 0; g < NUM_LINKS; g++) begin : g_bus
        assign weight_bus[g*LINK_BIT_WIDTH +: LINK_BIT_WIDTH] = entry_q[g].weight;
        assign boundary_bus[g*2 +: 2]                         = entry_q[g].boundary;
    end

    assign cfg_error = cfg_error_q;

endmodule

// File: rtl/link_config_loader.sv
// Loader FSM: fills the link parameter bus from the host stream, then overrides
// the global stage with STAGE_PARAMETERS_LOADING for one cycle.
module link_config_loader
    import link_config_loader_pkg::*;
(
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                start,
    input  logic                                abort,
    link_config_loader_if.slave                 cfg,
    input  logic [STAGE_WIDTH-1:0]              global_stage_in,
    output logic [STAGE_WIDTH-1:0]              global_stage_out,
    output logic [NUM_LINKS*LINK_BIT_WIDTH-1:0] weight_bus,
    output logic [NUM_LINKS*2-1:0]              boundary_bus,
    output logic                                busy,
    output logic                                done,
    output logic                                cfg_error
);

    loader_state_e        state_q, state_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic                 cfg_ready;
    logic                 shift_en;
    logic                 err_clr;
    link_cfg_t            word_in;

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_d          = state_q;
        count_d          = count_q;
        cfg_ready        = 1'b0;
        busy             = 1'b0;
        done             = 1'b0;
        shift_en         = 1'b0;
        err_clr          = 1'b0;
        global_stage_out = global_stage_in;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_FILL;
                    count_d = '0;
                    err_clr = 1'b1;
                end
            end
            ST_FILL: begin
                cfg_ready = 1'b1;
                busy      = 1'b1;
                // abort beats a same-cycle handshake: the word is dropped.
                if (abort) begin
                    state_d = ST_IDLE;
                    count_d = '0;
                end else if (cfg.cfg_valid) begin
                    shift_en = 1'b1;
                    count_d  = count_q + CNT_WIDTH'(1);
                    if (count_q == CNT_WIDTH'(NUM_LINKS - 1)) begin
                        state_d = ST_COMMIT;
                    end
                end
            end
            ST_COMMIT: begin
                busy             = 1'b1;
                global_stage_out = STAGE_PARAMETERS_LOADING;
                state_d          = ST_DONE;
            end
            ST_DONE: begin
                done = 1'b1;
                if (start) begin
                    state_d = ST_FILL;
                    count_d = '0;
                    err_clr = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    assign cfg.cfg_ready    = cfg_ready;
    assign word_in.weight   = cfg.cfg_weight;
    assign word_in.boundary = cfg.cfg_boundary;

    link_cfg_shift_chain u_chain (
        .clk          (clk),
        .reset        (reset),
        .shift_en     (shift_en),
        .err_clr      (err_clr),
        .word_in      (word_in),
        .weight_bus   (weight_bus),
        .boundary_bus (boundary_bus),
        .cfg_error    (cfg_error)
    );

endmodule

// File: tb/tb_link_config_loader.sv
// Directed bench for link_config_loader: stimulus pushes expected commit
// contents into a queue, a monitor pops and compares on every commit cycle.
module tb_link_config_loader;
    import link_config_loader_pkg::*;

    localparam int WB = NUM_LINKS * LINK_BIT_WIDTH;
    localparam int BB = NUM_LINKS * 2;

    logic                   clk = 1'b0;
    logic                   reset = 1'b0;
    logic                   start = 1'b0;
    logic                   abort = 1'b0;
    logic [STAGE_WIDTH-1:0] stage_in = '0;
    logic [STAGE_WIDTH-1:0] stage_out;
    logic [WB-1:0]          weight_bus;
    logic [BB-1:0]          boundary_bus;
    logic                   busy;
    logic                   done;
    logic                   cfg_error;

    link_config_loader_if hif ();

    link_config_loader u_dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .abort            (abort),
        .cfg              (hif.slave),
        .global_stage_in  (stage_in),
        .global_stage_out (stage_out),
        .weight_bus       (weight_bus),
        .boundary_bus     (boundary_bus),
        .busy             (busy),
        .done             (done),
        .cfg_error        (cfg_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WB-1:0] w;
        logic [BB-1:0] b;
        logic          e;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic push_exp(input logic [WB-1:0] w, input logic [BB-1:0] b, input logic e);
        exp_t x;
        x.w = w;
        x.b = b;
        x.e = e;
        exp_q.push_back(x);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Presents one word and waits (bounded) until it is accepted.
    task automatic send(input int w, input int b);
        bit hs;
        int n;
        hs = 1'b0;
        n  = 0;
        hif.cfg_valid    = 1'b1;
        hif.cfg_weight   = LINK_BIT_WIDTH'(w);
        hif.cfg_boundary = 2'(b);
        do begin
            @(negedge clk);
            hs = hif.cfg_ready && hif.cfg_valid;
            @(posedge clk);
            #1;
            n++;
        end while (!hs && n < 20);
        check("handshake", 32'(hs), 1);
        hif.cfg_valid = 1'b0;
    endtask

    // Called right after the last handshake edge: the next cycle must be the
    // single commit cycle, and DONE must follow with stable buses.
    task automatic commit_window(input logic [WB-1:0] w, input logic [BB-1:0] b);
        @(negedge clk);
        check("commit_cycle_stage", stage_out, STAGE_PARAMETERS_LOADING);
        check("commit_cycle_busy", busy, 1);
        check("commit_cycle_ready", hif.cfg_ready, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("done_after_commit", done, 1);
        check("stage_after_commit", stage_out, stage_in);
        check("weight_stable_in_done", weight_bus, w);
        check("boundary_stable_in_done", boundary_bus, b);
    endtask

    // Stage controller model: random codes, never STAGE_PARAMETERS_LOADING.
    initial begin : stage_drv
        int v;
        forever begin
            @(posedge clk);
            #2;
            v = $urandom_range(0, 6);
            stage_in = (v == 0) ? STAGE_IDLE : STAGE_WIDTH'(v + 1);
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (stage_out === STAGE_PARAMETERS_LOADING) begin
                check("commit_expected", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("commit_weight_bus", weight_bus, e.w);
                    check("commit_boundary_bus", boundary_bus, e.b);
                    check("commit_cfg_error", cfg_error, e.e);
                end
            end else begin
                check("stage_passthrough", stage_out, stage_in);
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish, actual timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        bit pat   [7];
        int pat_w [7];
        int pat_b [7];
        pat   = '{1, 0, 0, 1, 1, 0, 1};
        pat_w = '{1, 3, 3, 2, 0, 3, 1};
        pat_b = '{2, 3, 3, 1, 0, 3, 3};

        hif.cfg_valid    = 1'b0;
        hif.cfg_weight   = '0;
        hif.cfg_boundary = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #3;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_ready", hif.cfg_ready, 0);
        check("reset_weight_bus", weight_bus, 0);
        check("reset_boundary_bus", boundary_bus, 0);
        check("reset_cfg_error", cfg_error, 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("idle_busy", busy, 0);

        // Nominal load
        push_exp(8'h86, 8'h24, 1'b0);
        pulse_start();
        check("ready_one_cycle_after_start", hif.cfg_ready, 1);
        send(2, 0);
        send(1, 1);
        send(0, 2);
        send(2, 0);
        commit_window(8'h86, 8'h24);

        // Clamp, started from DONE
        push_exp(8'h26, 8'h63, 1'b1);
        pulse_start();
        send(3, 3);
        check("cfg_error_set_on_clamp", cfg_error, 1);
        send(1, 0);
        send(2, 2);
        send(0, 1);
        commit_window(8'h26, 8'h63);
        check("cfg_error_sticky_in_done", cfg_error, 1);

        // Gaps in cfg_valid
        push_exp(8'h49, 8'hC6, 1'b0);
        pulse_start();
        check("cfg_error_cleared_by_start", cfg_error, 0);
        for (int i = 0; i < 7; i++) begin
            hif.cfg_valid    = pat[i];
            hif.cfg_weight   = LINK_BIT_WIDTH'(pat_w[i]);
            hif.cfg_boundary = 2'(pat_b[i]);
            @(posedge clk);
            #1;
        end
        hif.cfg_valid = 1'b0;
        commit_window(8'h49, 8'hC6);
        check("count_full", 32'(u_dut.count_q), NUM_LINKS);

        // Abort after two words, with a word offered in the abort cycle
        pulse_start();
        send(2, 3);
        send(0, 1);
        hif.cfg_valid    = 1'b1;
        hif.cfg_weight   = LINK_BIT_WIDTH'(1);
        hif.cfg_boundary = 2'(1);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        hif.cfg_valid = 1'b0;
        check("abort_state_idle", 32'(u_dut.state_q), 32'(ST_IDLE));
        check("abort_busy", busy, 0);
        check("abort_ready", hif.cfg_ready, 0);
        check("abort_done", done, 0);
        check("abort_partial_weight", weight_bus, 8'h24);
        check("abort_partial_boundary", boundary_bus, 8'h7C);
        repeat (4) @(posedge clk);
        #1;
        check("abort_stays_idle", busy, 0);

        // Asynchronous reset mid-load
        pulse_start();
        send(1, 1);
        send(2, 2);
        send(0, 3);
        #2;
        reset = 1'b0;
        #1;
        check("midreset_busy", busy, 0);
        check("midreset_ready", hif.cfg_ready, 0);
        check("midreset_weight_bus", weight_bus, 0);
        check("midreset_boundary_bus", boundary_bus, 0);
        check("midreset_done", done, 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("after_midreset_idle", busy, 0);

        // Start while busy is ignored, count continues
        push_exp(8'hA4, 8'h1B, 1'b0);
        pulse_start();
        send(0, 3);
        send(1, 2);
        start = 1'b1;
        send(2, 1);
        start = 1'b0;
        check("start_in_fill_ignored", 32'(u_dut.state_q), 32'(ST_FILL));
        send(2, 0);
        commit_window(8'hA4, 8'h1B);

        // Reload from DONE overwrites every slot
        push_exp(8'h55, 8'h55, 1'b0);
        pulse_start();
        for (int i = 0; i < NUM_LINKS; i++) begin
            send(1, 1);
        end
        commit_window(8'h55, 8'h55);

        repeat (3) @(posedge clk);
        #1;
        check("all_commits_seen", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/link_config_loader.md
Name: link_config_loader

Overview:
- Configuration sequencer for an array of NUM_LINKS neighbor links.
- Accepts a host stream of per-link (weight, boundary_condition) words over a valid/ready handshake and shifts them into a per-link parameter bus.
- Once the bus holds a full set of words, it overrides the global stage with STAGE_PARAMETERS_LOADING for exactly one cycle so that every link latches its weight and boundary condition together.
- Sits between the top-level stage controller and the link array, on the global_stage path.

Parameters:
- NUM_LINKS, 4: number of links configured per load; must be at least 2.
- MAX_WEIGHT, 2: maximum legal link weight.
- LINK_BIT_WIDTH, $clog2(MAX_WEIGHT+1): width of one weight field.
- CNT_WIDTH, $clog2(NUM_LINKS+1): width of the word counter.

Ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a load.
- abort  in  1  cancels a load in progress.
- cfg_valid  in  1  host word valid.
- cfg_ready  out  1  loader can accept a word.
- cfg_weight  in  LINK_BIT_WIDTH  host weight field.
- cfg_boundary  in  2  host boundary_condition field.
- global_stage_in  in  STAGE_WIDTH  stage from the top-level controller.
- global_stage_out  out  STAGE_WIDTH  stage driven to the link array.
- weight_bus  out  NUM_LINKS*LINK_BIT_WIDTH  per-link weight_in; link i uses slice i.
- boundary_bus  out  NUM_LINKS*2  per-link boundary_condition_in; link i uses slice i.
- busy  out  1  high in FILL and COMMIT.
- done  out  1  high in DONE.
- cfg_error  out  1  sticky flag: a weight above MAX_WEIGHT was clamped.

Behaviour:
- Reset (reset low, asynchronous) puts every register in a known state:
  - state = IDLE; count = 0.
  - weight_bus, boundary_bus and cfg_error all 0.
  - Outputs: cfg_ready = 0, busy = 0, done = 0.
  - global_stage_out follows global_stage_in combinationally, so no stage override is ever emitted during or straight after reset.
- State machine:
  - IDLE, on start: go to FILL; count <= 0; cfg_error <= 0.
  - FILL: cfg_ready = 1. A handshake occurs when cfg_valid and cfg_ready are both high. On a handshake:
    - Shift the buses: entry[i] <= entry[i+1] for i < NUM_LINKS-1, and entry[NUM_LINKS-1] <= the new word.
    - count <= count + 1.
    - After the NUM_LINKS-th handshake, go to COMMIT on the next edge. The first word accepted ends up at index 0.
  - COMMIT: lasts exactly one cycle. global_stage_out = STAGE_PARAMETERS_LOADING and cfg_ready = 0. Then go to DONE.
  - DONE: done = 1 and global_stage_out = global_stage_in. On start: go to FILL, with the same effects as start in IDLE.
- Weight clamping: if cfg_weight > MAX_WEIGHT, the stored value is MAX_WEIGHT and cfg_error is set to 1. cfg_error stays set until the next start or reset.
- Boundary values: cfg_boundary is stored unmodified; values 2 and 3 are legal and mean a non-existent edge.
- abort:
  - In FILL: go to IDLE and set count <= 0. Buses keep their partial contents. No COMMIT is issued, so the links keep their previous configuration.
  - In COMMIT: abort is ignored and the commit completes.
  - When abort and a handshake occur in the same cycle, abort wins and the word is dropped.
- start while in FILL or COMMIT is ignored.
- Bus stability: the buses hold their values from COMMIT until the next accepted word, so the links see stable inputs on the latch edge.
- global_stage_out equals global_stage_in in every state except COMMIT. The override has no pipeline delay: it is combinational from state.
- cfg_ready is a registered-state decode with no combinational dependence on cfg_valid.
- Latency: from the start edge to the first possible handshake is 1 cycle. From the last handshake to the COMMIT cycle is 1 cycle.
- Counter: count never exceeds NUM_LINKS and never wraps.

Decomposition:
- STAGE_WIDTH and the STAGE_* encodings come from the shared parameters.sv include; no new stage codes are added.
- Add to the shared package:
  - the loader state enum (IDLE, FILL, COMMIT, DONE);
  - a link_cfg_t struct {weight, boundary}.
- One natural sub-module: link_cfg_shift_chain, i.e. the NUM_LINKS-entry shift register with a clamp on its input and the cfg_error set output. The FSM, counter and stage mux stay in link_config_loader.

Test Plan (NUM_LINKS=4, MAX_WEIGHT=2):
- Nominal load:
  - Stimulus: start, then words (2,0), (1,1), (0,2), (2,0) on back-to-back cycles with cfg_valid held high.
  - Response: weight_bus = {2,0,1,2} (index 3 down to 0), boundary_bus = {0,2,1,0}. Exactly one cycle of STAGE_PARAMETERS_LOADING, one cycle after the 4th handshake. done = 1 afterwards.
- Clamp:
  - Stimulus: one of the four words has weight 3.
  - Response: that slot is stored as 2 and cfg_error = 1. On the next start, cfg_error = 0.
- Gaps:
  - Stimulus: cfg_valid toggles 1,0,0,1,1,0,1.
  - Response: only 4 words are accepted, count reaches 4, COMMIT appears once, and no stage override occurs before that.
- Abort:
  - Stimulus: abort after 2 words, with cfg_valid high in the same cycle.
  - Response: state = IDLE, no STAGE_PARAMETERS_LOADING emitted, the word in the abort cycle is not shifted in, and global_stage_out tracks global_stage_in throughout.
- Reset mid-load:
  - Stimulus: reset low asynchronously after 3 words.
  - Response: immediately busy = 0, cfg_ready = 0, both buses 0, and no commit.
- Start while busy, then reload:
  - Stimulus: a start pulse in FILL.
  - Response: ignored, and the count continues.
  - Stimulus: start in DONE.
  - Response: a second full load overwrites all 4 slots.
